// File: rtl/mips16_multicycle_ctrl_pkg.sv
// Shared types for the mips16 multi-cycle controller:
// opcodes, ALU/mux encodings, FSM states, decode bundle.
package mips16_multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_NAND = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       is_mem;
        logic       is_store;
        logic       is_branch;
        logic       is_jalr;
        logic [1:0] wb_sel;
    } dec_t;

endpackage

// File: rtl/mips16_multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle.
// master = controller side, slave = memory side.
interface mips16_multicycle_ctrl_if;

    logic [15:0] instr;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  instr,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output instr,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/mips16_multicycle_ctrl_decode.sv
// Combinational opcode decode.
// i_op: instr[15:13]; o_dec: ALU op/src, class flags, wb_sel.
module mips16_multicycle_ctrl_decode
    import mips16_multicycle_ctrl_pkg::*;
(
    input  logic [2:0] i_op,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        unique case (i_op)
            OP_ADD: begin
                o_dec.alu_op = ALU_ADD;
            end
            OP_ADDI: begin
                o_dec.alu_op      = ALU_ADD;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_NAND: begin
                o_dec.alu_op = ALU_NAND;
            end
            OP_LUI: begin
                o_dec.alu_op      = ALU_LUI;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_SW: begin
                o_dec.alu_op      = ALU_ADD;
                o_dec.alu_src_imm = 1'b1;
                o_dec.is_mem      = 1'b1;
                o_dec.is_store    = 1'b1;
            end
            OP_LW: begin
                o_dec.alu_op      = ALU_ADD;
                o_dec.alu_src_imm = 1'b1;
                o_dec.is_mem      = 1'b1;
                o_dec.wb_sel      = WB_MEM;
            end
            OP_BEQ: begin
                o_dec.alu_op    = ALU_SUB;
                o_dec.is_branch = 1'b1;
            end
            OP_JALR: begin
                o_dec.is_jalr = 1'b1;
                o_dec.wb_sel  = WB_PC;
            end
        endcase
    end

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit CPU datapath.
// Ports: clk, rst (async, active-low), run, alu_zero,
//   mem (imem/dmem req/ack bundle), datapath enables
//   and selects, busy/halted/error status, retired count.
module mips16_multicycle_ctrl
    import mips16_multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             alu_zero,
    mips16_multicycle_ctrl_if.master mem,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t           r_state;
    logic [2:0]       r_op;
    logic             r_imm_nz;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;

    dec_t   w_dec;
    logic   w_ack;
    logic   w_tmo;
    state_t w_next_fetch;

    mips16_multicycle_ctrl_decode u_dec (
        .i_op  (r_op),
        .o_dec (w_dec)
    );

    // Completion in the same cycle as req; acks outside
    // the matching wait state are ignored.
    assign w_ack = (r_state == S_FETCH && mem.imem_ack)
                || (r_state == S_MEM && mem.dmem_ack);
    assign w_tmo = (r_state == S_FETCH || r_state == S_MEM)
                && !w_ack && (r_wait == TMO_LAST);

    // run is sampled only at an instruction boundary.
    assign w_next_fetch = run ? S_FETCH : S_IDLE;

    assign retired = r_retired;
    assign busy    = !(r_state == S_IDLE
                    || r_state == S_HALT
                    || r_state == S_ERROR);
    assign halted  = (r_state == S_HALT);
    assign error   = (r_state == S_ERROR);

    // Outputs decode from state so reset clears them at once;
    // fetch and branch enables follow ack/alu_zero same cycle.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_INC;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        alu_op       = ALU_NONE;
        alu_src_imm  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_EXEC: begin
                alu_op      = w_dec.alu_op;
                alu_src_imm = w_dec.alu_src_imm;
                if (w_dec.is_branch && alu_zero) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_BR;
                end
                if (w_dec.is_jalr && !r_imm_nz) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_JR;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = w_dec.is_store;
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = w_dec.wb_sel;
            end
            S_IDLE, S_DECODE, S_HALT, S_ERROR: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_imm_nz  <= 1'b0;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            // Wait counter only survives an unacked wait cycle.
            r_wait <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_op     <= mem.instr[15:13];
                        r_imm_nz <= |mem.instr[6:0];
                        r_state  <= S_DECODE;
                    end else if (w_tmo) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_dec.is_branch) begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= w_next_fetch;
                    end else if (w_dec.is_jalr && r_imm_nz) begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= S_HALT;
                    end else if (w_dec.is_mem) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_ack) begin
                        if (w_dec.is_store) begin
                            r_retired <= r_retired + CNT_W'(1);
                            r_state   <= w_next_fetch;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_tmo) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= w_next_fetch;
                end
                S_HALT, S_ERROR: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule
